// File: rtl/tlul_host_bridge.sv
// Single-outstanding TL-UL initiator: a simple command/response handshake
// becomes one Get/Put on the xbar host port, with D-channel timeout.

package tlul_pkg;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned SW = 8;
    localparam int unsigned UW = 16;

    localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] GET              = 3'h4;
    localparam logic [2:0] ACCESS_ACK       = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

    localparam logic [UW-1:0] A_USER_DEFAULT = '0;

    typedef struct packed {
        logic          a_valid;
        logic [2:0]    a_opcode;
        logic [2:0]    a_param;
        logic [1:0]    a_size;
        logic [SW-1:0] a_source;
        logic [AW-1:0] a_address;
        logic [MW-1:0] a_mask;
        logic [DW-1:0] a_data;
        logic [UW-1:0] a_user;
        logic          d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic          d_valid;
        logic [2:0]    d_opcode;
        logic [2:0]    d_param;
        logic [1:0]    d_size;
        logic [SW-1:0] d_source;
        logic          d_sink;
        logic [DW-1:0] d_data;
        logic [UW-1:0] d_user;
        logic          d_error;
        logic          a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_bridge #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [7:0]  SrcBase       = 8'h40
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [31:0]       cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o
);
    import tlul_pkg::*;

    localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]      state_q, state_n;
    logic [1:0]      tag_q, tag_n;
    logic [CntW-1:0] cnt_q, cnt_n;
    tl_h2d_t         a_q, a_n;
    logic            cmd_ready_q, cmd_ready_n;
    logic            rsp_valid_q, rsp_valid_n;
    logic [31:0]     rsp_rdata_q, rsp_rdata_n;
    logic            rsp_err_q, rsp_err_n;
    logic            rsp_timeout_q, rsp_timeout_n;

    logic unused_bits;
    assign unused_bits = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user,
                           cmd_addr_i[1:0]};

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            tag_q         <= 2'd0;
            cnt_q         <= '0;
            a_q           <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_n;
            tag_q         <= tag_n;
            cnt_q         <= cnt_n;
            a_q           <= a_n;
            cmd_ready_q   <= cmd_ready_n;
            rsp_valid_q   <= rsp_valid_n;
            rsp_rdata_q   <= rsp_rdata_n;
            rsp_err_q     <= rsp_err_n;
            rsp_timeout_q <= rsp_timeout_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n       = state_q;
        tag_n         = tag_q;
        cnt_n         = cnt_q;
        a_n           = a_q;
        a_n.d_ready   = 1'b1;
        rsp_valid_n   = rsp_valid_q;
        rsp_rdata_n   = rsp_rdata_q;
        rsp_err_n     = rsp_err_q;
        rsp_timeout_n = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    a_n.a_address = {cmd_addr_i[31:2], 2'b00};
                    a_n.a_size    = 2'd2;
                    a_n.a_param   = 3'd0;
                    a_n.a_source  = {SrcBase[7:2], tag_q};
                    a_n.a_user    = A_USER_DEFAULT;
                    if (cmd_we_i) begin
                        a_n.a_opcode = (cmd_be_i == 4'hF) ? PUT_FULL_DATA : PUT_PARTIAL_DATA;
                        a_n.a_mask   = cmd_be_i;
                        a_n.a_data   = cmd_wdata_i;
                    end else begin
                        a_n.a_opcode = GET;
                        a_n.a_mask   = 4'hF;
                        a_n.a_data   = 32'd0;
                    end
                    // A write with no enabled bytes is rejected without touching the bus
                    if (cmd_we_i && (cmd_be_i == 4'h0)) begin
                        state_n     = ST_DONE;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        state_n     = ST_REQ;
                        a_n.a_valid = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (tl_i.a_ready) begin
                    a_n.a_valid = 1'b0;
                    cnt_n       = '0;
                    state_n     = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_n = cnt_q + CntW'(1);
                if (tl_i.d_valid && a_q.d_ready && (tl_i.d_source == a_q.a_source)) begin
                    state_n     = ST_DONE;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = tl_i.d_error;
                    rsp_rdata_n = (tl_i.d_opcode == ACCESS_ACK_DATA && !tl_i.d_error)
                                  ? tl_i.d_data : 32'd0;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_n       = ST_DONE;
                    rsp_valid_n   = 1'b1;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    rsp_rdata_n   = 32'd0;
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) begin
                    state_n       = ST_IDLE;
                    tag_n         = tag_q + 2'd1;
                    rsp_valid_n   = 1'b0;
                    rsp_rdata_n   = 32'd0;
                    rsp_err_n     = 1'b0;
                    rsp_timeout_n = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        cmd_ready_n = (state_n == ST_IDLE);
    end

    assign tl_o          = a_q;
    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
endmodule

// File: tb/tb_tlul_host_bridge.sv
// Directed bench for tlul_host_bridge: reads, partial/full writes, errors,
// timeout with stale late beat, rejected empty write and mid-flight reset.

module tb_tlul_host_bridge;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [3:0]  cmd_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int cycles;

    always #5 clk = ~clk;

    tlul_host_bridge #(.TimeoutCycles(8), .SrcBase(8'h40)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_o         (tl_h2d),
        .tl_i         (tl_d2h),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_be_i     (cmd_be),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted (bounded)
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bit done;
        done      = 1'b0;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) check("cmd_accept", 32'd0, 32'd1);
    endtask

    task automatic a_accept();
        tl_d2h.a_ready = 1'b1;
        tick();
        tl_d2h.a_ready = 1'b0;
    endtask

    task automatic d_beat(input logic [7:0] src, input logic [2:0] op,
                          input logic [31:0] data, input logic err);
        tl_d2h.d_valid  = 1'b1;
        tl_d2h.d_source = src;
        tl_d2h.d_opcode = op;
        tl_d2h.d_data   = data;
        tl_d2h.d_error  = err;
        tick();
        tl_d2h.d_valid  = 1'b0;
        tl_d2h.d_data   = 32'd0;
        tl_d2h.d_error  = 1'b0;
    endtask

    task automatic rsp_take();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        check("rst_d_ready", 32'(tl_h2d.d_ready), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp", {28'd0, rsp_valid, rsp_err, rsp_timeout, |rsp_rdata}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_d_ready", 32'(tl_h2d.d_ready), 32'd1);

        // Read, AccessAckData
        issue(1'b0, 32'h8000_0013, 32'hFFFF_FFFF, 4'h0);
        check("rd_a_valid", 32'(tl_h2d.a_valid), 32'd1);
        check("rd_opcode", 32'(tl_h2d.a_opcode), 32'd4);
        check("rd_mask", 32'(tl_h2d.a_mask), 32'hF);
        check("rd_source", 32'(tl_h2d.a_source), 32'h40);
        check("rd_address", tl_h2d.a_address, 32'h8000_0010);
        check("rd_size", 32'(tl_h2d.a_size), 32'd2);
        check("rd_data", tl_h2d.a_data, 32'd0);
        a_accept();
        check("rd_a_drop", 32'(tl_h2d.a_valid), 32'd0);
        check("rd_rsp_early", 32'(rsp_valid), 32'd0);
        d_beat(8'h40, ACCESS_ACK_DATA, 32'hDEAD_BEEF, 1'b0);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        tick();
        check("rd_rsp_hold", rsp_rdata, 32'hDEAD_BEEF);
        rsp_take();
        check("rd_rsp_clear", {rsp_rdata[31:1], rsp_rdata[0] | rsp_valid}, 32'd0);
        check("rd_cmd_ready", 32'(cmd_ready), 32'd1);

        // Partial write, a_ready held low for 5 cycles
        issue(1'b1, 32'h8000_0004, 32'h1234_5678, 4'h3);
        for (int i = 0; i < 5; i++) begin
            check("pw_a_valid_held", 32'(tl_h2d.a_valid), 32'd1);
            check("pw_opcode", 32'(tl_h2d.a_opcode), 32'd1);
            check("pw_mask", 32'(tl_h2d.a_mask), 32'h3);
            check("pw_data", tl_h2d.a_data, 32'h1234_5678);
            tick();
        end
        check("pw_source", 32'(tl_h2d.a_source), 32'h41);
        a_accept();
        d_beat(8'h41, ACCESS_ACK, 32'hFFFF_FFFF, 1'b0);
        check("pw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("pw_rdata", rsp_rdata, 32'd0);
        check("pw_err", 32'(rsp_err), 32'd0);
        rsp_take();

        // Full write, device error
        issue(1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 4'hF);
        check("fw_opcode", 32'(tl_h2d.a_opcode), 32'd0);
        check("fw_mask", 32'(tl_h2d.a_mask), 32'hF);
        check("fw_source", 32'(tl_h2d.a_source), 32'h42);
        a_accept();
        d_beat(8'h42, ACCESS_ACK, 32'd0, 1'b1);
        check("fw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("fw_err", 32'(rsp_err), 32'd1);
        check("fw_timeout", 32'(rsp_timeout), 32'd0);
        rsp_take();

        // Write with be == 0: rejected, no bus traffic
        issue(1'b1, 32'h8000_000C, 32'h1111_1111, 4'h0);
        check("be0_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        check("be0_rsp_valid", 32'(rsp_valid), 32'd1);
        check("be0_err", {30'd0, rsp_err, rsp_timeout}, 32'd2);
        tick();
        check("be0_a_valid_later", 32'(tl_h2d.a_valid), 32'd0);
        // Response consumed while a new command waits: not accepted in DONE
        cmd_we    = 1'b0;
        cmd_addr  = 32'h8000_0020;
        cmd_valid = 1'b1;
        rsp_take();
        check("done_no_accept_a", 32'(tl_h2d.a_valid), 32'd0);
        check("done_no_accept_rdy", 32'(cmd_ready), 32'd1);

        // Timeout: tag wrapped back to 0
        issue(1'b0, 32'h8000_0020, 32'd0, 4'h0);
        check("to_source", 32'(tl_h2d.a_source), 32'h40);
        a_accept();
        cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        // A handshake ends cycle A; response shows in cycle A+9
        check("to_latency", 32'(cycles + 1), 32'd9);
        check("to_flags", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd7);
        check("to_rdata", rsp_rdata, 32'd0);
        rsp_take();

        // Next read uses tag 1; stale beat for tag 0 is dropped
        issue(1'b0, 32'h8000_0030, 32'd0, 4'h0);
        check("late_source", 32'(tl_h2d.a_source), 32'h41);
        a_accept();
        d_beat(8'h40, ACCESS_ACK_DATA, 32'hBADB_AD00, 1'b0);
        check("late_dropped", 32'(rsp_valid), 32'd0);
        check("late_d_ready", 32'(tl_h2d.d_ready), 32'd1);
        d_beat(8'h41, ACCESS_ACK_DATA, 32'hCAFE_F00D, 1'b0);
        check("late_rsp_valid", 32'(rsp_valid), 32'd1);
        check("late_rdata", rsp_rdata, 32'hCAFE_F00D);
        check("late_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        rsp_take();

        // Reset while waiting for D
        issue(1'b0, 32'h8000_0040, 32'd0, 4'h0);
        check("mr_source", 32'(tl_h2d.a_source), 32'h42);
        a_accept();
        rst = 1'b1;
        tick();
        check("mr_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mr_d_ready", 32'(tl_h2d.d_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("mr_idle", 32'(cmd_ready), 32'd1);
        issue(1'b0, 32'h8000_0044, 32'd0, 4'h0);
        check("mr_tag_reset", 32'(tl_h2d.a_source), 32'h40);
        a_accept();
        d_beat(8'h40, ACCESS_ACK_DATA, 32'h0000_5A5A, 1'b0);
        check("mr_rdata", rsp_rdata, 32'h0000_5A5A);
        rsp_take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
